// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter_if
// Description : Avalon-MM bus bundle shared by the two arbiter masters and
//               the SDRAM-side port.
//               Signals are address, read, write, writedata (driven by the
//               bus master) and waitrequest, readdata, readdatavalid
//               (driven by the slave).
//               modport master : the side that issues transfers
//               modport slave  : the side that answers them
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Shares one SDRAM Avalon-MM port between two masters
//               (m0 = word-copy accelerator, m1 = CPU/NN path).
//               Round-robin grant held for a whole transfer; a tag FIFO
//               routes pipelined read responses back to the issuing master.
//               Optional macro ARB_FIXED_PRIO_EN: m0 always wins a tie.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               m0    - slave modport facing master 0
//               m1    - slave modport facing master 1
//               s     - master modport facing the SDRAM controller
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdram_port_arbiter_if.slave   m0,
  sdram_port_arbiter_if.slave   m1,
  sdram_port_arbiter_if.master  s
);

  localparam int               c_PTR_W   = $clog2(TAG_DEPTH);
  localparam logic [c_PTR_W:0] c_FULL    = (c_PTR_W+1)'(TAG_DEPTH);
  localparam logic [c_PTR_W:0] c_CNT_ONE = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last;
  logic [TAG_DEPTH-1:0]  r_tag_mem;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W:0]      r_count;
  logic                  r_resp_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_m0_req;
  logic                  w_m1_req;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head;
  logic [ADDR_W-1:0]     w_s_address;
  logic                  w_s_read;
  logic                  w_s_write;
  logic [DATA_W-1:0]     w_s_writedata;
  logic                  w_m0_wait;
  logic                  w_m1_wait;
  logic                  w_m0_rdv;
  logic                  w_m1_rdv;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

  // A read cannot be issued while every tag slot is in use; a write still
  // can, so a read+write request stays eligible through the write.
  assign w_m0_req = m0.write | (m0.read & ~w_full);
  assign w_m1_req = m1.write | (m1.read & ~w_full);

  always_comb begin
    w_state_nxt   = r_state;
    w_s_address   = '0;
    w_s_read      = 1'b0;
    w_s_write     = 1'b0;
    w_s_writedata = '0;
    w_m0_wait     = 1'b1;
    w_m1_wait     = 1'b1;
    w_accept      = 1'b0;

    unique case (r_state)
      ARB: begin
        if (w_m0_req && w_m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
          w_state_nxt = OWN0;
`else
          // Tie goes to whichever master was not served last.
          w_state_nxt = r_last ? OWN0 : OWN1;
`endif
        end else if (w_m0_req) begin
          w_state_nxt = OWN0;
        end else if (w_m1_req) begin
          w_state_nxt = OWN1;
        end
      end

      OWN0: begin
        w_s_address   = m0.address;
        w_s_write     = m0.write;
        w_s_read      = m0.read & ~m0.write;  // write wins over read
        w_s_writedata = m0.writedata;
        w_m0_wait     = s.waitrequest;
        w_accept      = (w_s_read | w_s_write) & ~s.waitrequest;
        // Leaving without acceptance covers a master that abandons its
        // request mid-stall.
        if (w_accept || !w_m0_req) w_state_nxt = ARB;
      end

      OWN1: begin
        w_s_address   = m1.address;
        w_s_write     = m1.write;
        w_s_read      = m1.read & ~m1.write;
        w_s_writedata = m1.writedata;
        w_m1_wait     = s.waitrequest;
        w_accept      = (w_s_read | w_s_write) & ~s.waitrequest;
        if (w_accept || !w_m1_req) w_state_nxt = ARB;
      end

      default: w_state_nxt = ARB;
    endcase
  end

  assign w_push = w_accept & w_s_read;
  // A response with no outstanding tag is dropped rather than routed.
  assign w_pop  = s.readdatavalid & ~w_empty;
  assign w_head = r_tag_mem[r_rd_ptr];

  assign w_m0_rdv = w_pop & ~w_head;
  assign w_m1_rdv = w_pop &  w_head;

  assign s.address     = w_s_address;
  assign s.read        = w_s_read;
  assign s.write       = w_s_write;
  assign s.writedata   = w_s_writedata;

  assign m0.waitrequest   = w_m0_wait;
  assign m1.waitrequest   = w_m1_wait;
  assign m0.readdatavalid = w_m0_rdv;
  assign m1.readdatavalid = w_m1_rdv;
  assign m0.readdata      = w_m0_rdv ? s.readdata : '0;
  assign m1.readdata      = w_m1_rdv ? s.readdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_last     <= 1'b1;
      r_tag_mem  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) r_last <= (r_state == OWN1);

      if (w_push) begin
        r_tag_mem[r_wr_ptr] <= (r_state == OWN1);
        r_wr_ptr            <= r_wr_ptr + c_PTR_ONE;
      end

      if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;

      // Push eligibility was decided on the start-of-cycle count, so a
      // simultaneous push and pop simply leaves the count alone.
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase

      if (s.readdatavalid && w_empty) r_resp_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Directed self-checking bench for sdram_port_arbiter.
//               Issued reads queue their master id; each SDRAM response pairs
//               the oldest id with its data into a scoreboard that a negedge
//               monitor drains against m0/m1 readdata.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  typedef struct {
    bit          port;
    logic [31:0] data;
  } resp_t;

  int    n_checks = 0;
  int    n_errors = 0;
  bit    q_port[$];
  resp_t q_resp[$];
  bit    model_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = addr; m0_if.writedata = wd;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = addr; m1_if.writedata = wd;
    end
  endtask

  // Returns at a negedge where s_read or s_write is visible.
  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (s_if.read || s_if.write) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("grant_timeout", {63'd0, got}, 64'd1);
  endtask

  task automatic read_xfer(input int p, input logic [31:0] addr);
    bit got;
    set_req(p, 1'b1, 1'b0, addr, 32'd0);
    s_if.waitrequest = 1'b0;
    wait_grant(got);
    chk("rd_addr",      s_if.address, addr);
    chk("rd_sread",     s_if.read, 1);
    chk("rd_own_wait",  (p == 0) ? m0_if.waitrequest : m1_if.waitrequest, 0);
    chk("rd_other_wait",(p == 0) ? m1_if.waitrequest : m0_if.waitrequest, 1);
    @(posedge clk); #1;
    set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
    if (got) begin
      q_port.push_back(p[0]);
      model_last = p[0];
    end
  endtask

  // Called just after a posedge; drives one response cycle.
  task automatic respond(input logic [31:0] data);
    resp_t e;
    e.port = q_port.pop_front();
    e.data = data;
    q_resp.push_back(e);
    s_if.readdatavalid = 1'b1;
    s_if.readdata      = data;
    @(posedge clk); #1;
    s_if.readdatavalid = 1'b0;
    s_if.readdata      = 32'd0;
    chk("resp_drained", q_resp.size(), 0);
  endtask

  // Scoreboard monitor: every valid response must match the oldest entry.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && (m0_if.readdatavalid || m1_if.readdatavalid)) begin
      if (q_resp.size() == 0) begin
        chk("unexpected_rdv", {62'd0, m1_if.readdatavalid, m0_if.readdatavalid}, 0);
      end else begin
        e = q_resp.pop_front();
        chk("rsp_m0_valid", m0_if.readdatavalid, (e.port == 0) ? 1 : 0);
        chk("rsp_m1_valid", m1_if.readdatavalid, (e.port == 1) ? 1 : 0);
        chk("rsp_m0_data",  m0_if.readdata, (e.port == 0) ? e.data : 32'd0);
        chk("rsp_m1_data",  m1_if.readdata, (e.port == 1) ? e.data : 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    bit exp_own;
    bit owner;
    int n_w[2];

    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    s_if.waitrequest   = 1'b0;
    s_if.readdata      = 32'd0;
    s_if.readdatavalid = 1'b0;
    model_last = 1'b1;

    // ---------------- reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_addr",  s_if.address, 0);
    chk("rst_s_read",  s_if.read, 0);
    chk("rst_s_write", s_if.write, 0);
    chk("rst_s_wd",    s_if.writedata, 0);
    chk("rst_m0_wait", m0_if.waitrequest, 1);
    chk("rst_m1_wait", m1_if.waitrequest, 1);
    chk("rst_m0_rdv",  m0_if.readdatavalid, 0);
    chk("rst_m1_rdv",  m1_if.readdatavalid, 0);
    chk("rst_m0_rd",   m0_if.readdata, 0);
    chk("rst_m1_rd",   m1_if.readdata, 0);
    chk("rst_count",   dut.r_count, 0);
    chk("rst_resp_err",dut.r_resp_err, 0);
    chk("rst_last",    dut.r_last, 1);
    chk("rst_state",   dut.r_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---------------- single read
    read_xfer(0, 32'h100);
    @(negedge clk);
    chk("single_sread_1cyc", s_if.read, 0);
    chk("single_count", dut.r_count, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    respond(32'hDEADBEEF);

    // ---------------- read+write together: write wins, no tag
    set_req(0, 1'b1, 1'b1, 32'h300, 32'h77);
    wait_grant(got);
    chk("excl_sread",  s_if.read, 0);
    chk("excl_swrite", s_if.write, 1);
    chk("excl_wd",     s_if.writedata, 32'h77);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    model_last = 1'b0;
    @(negedge clk);
    chk("excl_no_push", dut.r_count, 0);

    // ---------------- contention: both masters write continuously
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b1, 32'h0,  32'hA0);
    set_req(1, 1'b0, 1'b1, 32'h40, 32'hB0);
    n_w[0] = 0;
    n_w[1] = 0;
    for (int t = 0; t < 8; t++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_own = 1'b0;
`else
      exp_own = ~model_last;
`endif
      wait_grant(got);
      owner = (s_if.address == 32'h40);
      chk("cont_owner", owner, exp_own);
      chk("cont_wd", s_if.writedata, exp_own ? 32'hB0 : 32'hA0);
      n_w[owner]++;
      model_last = exp_own;
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
`ifdef ARB_FIXED_PRIO_EN
    chk("cont_m0_count", n_w[0], 8);
    chk("cont_m1_count", n_w[1], 0);
`else
    chk("cont_m0_count", n_w[0], 4);
    chk("cont_m1_count", n_w[1], 4);
`endif

    // ---------------- stall hold
    set_req(1, 1'b1, 1'b0, 32'h200, 32'd0);
    s_if.waitrequest = 1'b1;
    wait_grant(got);
    for (int k = 0; k < 5; k++) begin
      chk("stall_addr",    s_if.address, 32'h200);
      chk("stall_m0_wait", m0_if.waitrequest, 1);
      chk("stall_m1_wait", m1_if.waitrequest, 1);
      chk("stall_count",   dut.r_count, 0);
      @(posedge clk); #1;
      if (k == 4) s_if.waitrequest = 1'b0;
      @(negedge clk);
    end
    chk("stall_release_addr", s_if.address, 32'h200);
    chk("stall_release_wait", m1_if.waitrequest, 0);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    q_port.push_back(1'b1);
    model_last = 1'b1;
    @(negedge clk);
    chk("stall_one_push", dut.r_count, 1);
    @(posedge clk); #1;
    respond(32'h5A5A5A5A);

    // ---------------- pipelined interleaved reads
    read_xfer(0, 32'h10);
    read_xfer(1, 32'h20);
    read_xfer(0, 32'h30);
    read_xfer(1, 32'h40);
    chk("pipe_count", dut.r_count, 4);
    respond(32'h11);
    respond(32'h22);
    respond(32'h33);
    respond(32'h44);
    chk("pipe_empty", dut.r_count, 0);

    // ---------------- FIFO full blocks reads
    read_xfer(0, 32'h1000);
    read_xfer(1, 32'h1004);
    read_xfer(0, 32'h1008);
    read_xfer(1, 32'h100C);
    chk("full_count", dut.r_count, TD);
    set_req(0, 1'b1, 1'b0, 32'h5000, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_sread_blocked", s_if.read, 0);
      chk("full_m0_wait", m0_if.waitrequest, 1);
      @(posedge clk); #1;
    end
    respond(32'hA1);
    @(negedge clk);
    chk("full_arb_cycle", s_if.read, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_5th_sread", s_if.read, 1);
    chk("full_5th_addr",  s_if.address, 32'h5000);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    q_port.push_back(1'b0);
    model_last = 1'b0;
    respond(32'hA2);
    respond(32'hA3);
    respond(32'hA4);
    respond(32'hA5);
    chk("full_drained", dut.r_count, 0);

    // ---------------- spurious response
    s_if.readdatavalid = 1'b1;
    s_if.readdata      = 32'hBAD;
    @(negedge clk);
    chk("spur_m0_rdv", m0_if.readdatavalid, 0);
    chk("spur_m1_rdv", m1_if.readdatavalid, 0);
    @(posedge clk); #1;
    s_if.readdatavalid = 1'b0;
    s_if.readdata      = 32'd0;
    chk("spur_resp_err", dut.r_resp_err, 1);

    // ---------------- reset with reads outstanding
    read_xfer(0, 32'h600);
    read_xfer(1, 32'h700);
    chk("rst2_pre_count", dut.r_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_count",    dut.r_count, 0);
    chk("rst2_resp_err", dut.r_resp_err, 0);
    chk("rst2_last",     dut.r_last, 1);
    chk("rst2_s_read",   s_if.read, 0);
    chk("rst2_m0_wait",  m0_if.waitrequest, 1);
    chk("rst2_m1_wait",  m1_if.waitrequest, 1);
    q_port.delete();
    model_last = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // A late response for a discarded tag is spurious.
    s_if.readdatavalid = 1'b1;
    s_if.readdata      = 32'h600D;
    @(negedge clk);
    chk("late_m0_rdv", m0_if.readdatavalid, 0);
    chk("late_m1_rdv", m1_if.readdatavalid, 0);
    @(posedge clk); #1;
    s_if.readdatavalid = 1'b0;
    s_if.readdata      = 32'd0;
    chk("late_resp_err", dut.r_resp_err, 1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
